// File: rtl/sub_seq_clk.sv
// Multi-cycle subtractor: d = a - b - bi, CHUNK bits per cycle with a registered
// inter-chunk borrow and a start/busy/done handshake.
module sub_seq_clk #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bi,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bo,
  output logic             ov
);

  localparam int unsigned N  = WIDTH / CHUNK;
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             borrow_q;
  logic [IW-1:0]    idx_q;
  logic [WIDTH-1:0] diff_q;
  logic [WIDTH-1:0] d_q;
  logic             bo_q;
  logic             ov_q;
  logic             busy_q;
  logic             done_q;

  int unsigned      base_c;
  logic [CHUNK-1:0] a_ch_c;
  logic [CHUNK-1:0] b_ch_c;
  logic [CHUNK:0]   sum_c;
  logic             ov_c;
  logic [WIDTH-1:0] diff_nxt_c;

  // One chunk of a + ~b + ~borrow; overflow term is only used on the top chunk
  always_comb begin
    base_c     = 32'(idx_q) * CHUNK;
    a_ch_c     = a_q[base_c +: CHUNK];
    b_ch_c     = b_q[base_c +: CHUNK];
    sum_c      = {1'b0, a_ch_c} + {1'b0, ~b_ch_c} + {{CHUNK{1'b0}}, ~borrow_q};
    ov_c       = (a_ch_c[CHUNK-1] ^ b_ch_c[CHUNK-1]) & (a_ch_c[CHUNK-1] ^ sum_c[CHUNK-1]);
    diff_nxt_c = diff_q;
    diff_nxt_c[base_c +: CHUNK] = sum_c[CHUNK-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      borrow_q <= 1'b0;
      idx_q    <= '0;
      diff_q   <= '0;
      d_q      <= '0;
      bo_q     <= 1'b0;
      ov_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == S_CALC) begin
        diff_q   <= diff_nxt_c;
        borrow_q <= ~sum_c[CHUNK];
        if (idx_q == LAST) begin
          state_q <= S_DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          d_q     <= diff_nxt_c;
          bo_q    <= ~sum_c[CHUNK];
          ov_q    <= ov_c;
        end else begin
          idx_q <= idx_q + IW'(1);
        end
      end else if (start) begin
        // IDLE or DONE: accept a new operation (back-to-back from DONE)
        state_q  <= S_CALC;
        busy_q   <= 1'b1;
        a_q      <= a;
        b_q      <= b;
        borrow_q <= bi;
        idx_q    <= '0;
        diff_q   <= '0;
      end else begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
      end
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign d    = d_q;
  assign bo   = bo_q;
  assign ov   = ov_q;

endmodule
